// File: rtl/pico_axil_rom_bridge_pkg.sv
// Shared definitions for the AXI4-Lite to Avalon-MM ROM bridge:
// response codes, bridge FSM states and the ROM window decode helper.
package pico_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_RESP,
    WR_RESP
  } state_t;

  // True when addr falls inside [base, base + 4*2^aw). The subtraction wraps,
  // so addresses below base become huge offsets and fail the compare.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int unsigned aw);
    logic [32:0] offset;
    offset = {1'b0, addr - base};
    return offset < (33'd4 << aw);
  endfunction

endpackage

// File: rtl/pico_axil_rom_bridge_if.sv
// AXI4-Lite channel bundle between the interconnect (master) and the bridge (slave).
interface pico_axil_rom_bridge_if;

  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/pico_axil_rom_bridge.sv
// AXI4-Lite slave that serialises reads and writes into single accesses of a
// fixed 1-cycle-latency Avalon-MM ROM, one transaction in flight at a time.
module pico_axil_rom_bridge
  import pico_axil_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ROM_AW      = 12,
  parameter bit          ALLOW_WRITE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  pico_axil_rom_bridge_if.slave s,
  output logic [ROM_AW-1:0]     rom_address,
  output logic [3:0]            rom_byteenable,
  output logic                  rom_chipselect,
  output logic                  rom_write,
  output logic [31:0]           rom_writedata,
  output logic                  rom_debugaccess,
  output logic                  rom_clken,
  output logic                  rom_reset_req,
  input  logic [31:0]           rom_readdata
);

  state_t      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        last_wr_q, last_wr_d;   // 1 = write was served last, so a read wins a tie
  logic        rd_req, wr_req;

  assign rd_req = s.arvalid;
  assign wr_req = s.awvalid & s.wvalid;   // AW or W alone is never accepted

  assign s.rvalid = (state_q == RD_RESP);
  assign s.rdata  = rdata_q;
  assign s.rresp  = rresp_q;
  assign s.bvalid = (state_q == WR_RESP);
  assign s.bresp  = bresp_q;

  assign rom_debugaccess = rom_write;
  assign rom_clken       = 1'b1;
  assign rom_reset_req   = 1'b0;

  // State and response registers; reset drops any pending response.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      bresp_q   <= RESP_OKAY;
      last_wr_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      bresp_q   <= bresp_d;
      last_wr_q <= last_wr_d;
    end
  end

  // Next-state, AXI readies and ROM strobes; everything is held quiet during reset.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // statement leaves a signal unassigned and infers a latch.
    state_d        = state_q;
    rdata_d        = rdata_q;
    rresp_d        = rresp_q;
    bresp_d        = bresp_q;
    last_wr_d      = last_wr_q;
    s.arready      = 1'b0;
    s.awready      = 1'b0;
    s.wready       = 1'b0;
    rom_address    = '0;
    rom_byteenable = 4'h0;
    rom_chipselect = 1'b0;
    rom_write      = 1'b0;
    rom_writedata  = '0;

    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (rd_req && (!wr_req || last_wr_q)) begin
            s.arready = 1'b1;
            last_wr_d = 1'b0;
            if (in_window(s.araddr, BASE_ADDR, ROM_AW)) begin
              rom_address    = s.araddr[ROM_AW+1:2];
              rom_byteenable = 4'hF;
              rom_chipselect = 1'b1;
              state_d        = RD_WAIT;
            end else begin
              rdata_d = '0;
              rresp_d = RESP_DECERR;
              state_d = RD_RESP;
            end
          end else if (wr_req) begin
            s.awready = 1'b1;
            s.wready  = 1'b1;
            last_wr_d = 1'b1;
            state_d   = WR_RESP;
            if (!in_window(s.awaddr, BASE_ADDR, ROM_AW)) begin
              bresp_d = RESP_DECERR;
            end else if (!ALLOW_WRITE) begin
              bresp_d = RESP_SLVERR;
            end else begin
              rom_address    = s.awaddr[ROM_AW+1:2];
              rom_byteenable = s.wstrb;
              rom_chipselect = 1'b1;
              rom_write      = 1'b1;
              rom_writedata  = s.wdata;
              bresp_d        = RESP_OKAY;
            end
          end
        end
        RD_WAIT: begin
          // ROM q is valid exactly one cycle after the address edge.
          rdata_d = rom_readdata;
          rresp_d = RESP_OKAY;
          state_d = RD_RESP;
        end
        RD_RESP: if (s.rready) state_d = IDLE;
        WR_RESP: if (s.bready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: doc/pico_axil_rom_bridge.md
Name: pico_axil_rom_bridge

Overview:
- AXI4-Lite slave to Avalon-MM fixed-latency bridge. It sits between the system AXI-Lite interconnect (PicoRV32 side) and the 4096x32 on-chip program ROM, whose Avalon slave has 1-cycle read latency and unregistered q.
- Serialises AXI read/write channels into single ROM accesses, registers ROM read data, returns AXI responses.
- Decodes the ROM window and gates debug writes.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte base address of the ROM window; must be aligned to window size.
- ROM_AW, 12, ROM word-address width; window is 4*2^ROM_AW bytes.
- ALLOW_WRITE, 0, 1 = writes reach the ROM via debugaccess; 0 = writes rejected with SLVERR.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- s_awaddr  in  32  write address
- s_awvalid/s_awready  in/out  1  AW handshake
- s_wdata  in  32  write data
- s_wstrb  in  4  write byte strobes
- s_wvalid/s_wready  in/out  1  W handshake
- s_bresp  out  2  write response
- s_bvalid/s_bready  out/in  1  B handshake
- s_araddr  in  32  read address
- s_arvalid/s_arready  in/out  1  AR handshake
- s_rdata  out  32  read data
- s_rresp  out  2  read response
- s_rvalid/s_rready  out/in  1  R handshake
- rom_address  out  ROM_AW  word address, from addr[ROM_AW+1:2]
- rom_byteenable  out  4  byte enables (4'hF on reads)
- rom_chipselect  out  1  access strobe
- rom_write  out  1  write strobe
- rom_writedata  out  32  write data
- rom_debugaccess  out  1  equals rom_write
- rom_clken  out  1  tied 1
- rom_reset_req  out  1  tied 0
- rom_readdata  in  32  ROM q, valid the cycle after the address edge

Behaviour:
- Reset values: all s_*ready=0, s_bvalid=0, s_rvalid=0, s_rdata=0, s_rresp=0, s_bresp=0, rom_chipselect=0, rom_write=0, rom_address=0, FSM=IDLE.
- One transaction in flight at a time. FSM states: IDLE, RD_WAIT, RD_RESP, WR_RESP.
- IDLE, read selected (s_arvalid=1):
  - s_arready=1 for one cycle; latch address.
  - In range: drive rom_address and chipselect that cycle; go to RD_WAIT.
  - Out of range: go to RD_RESP with rresp=DECERR(2'b11), rdata=0, no ROM access.
- RD_WAIT: capture rom_readdata into s_rdata, rresp=OKAY; go to RD_RESP.
- Read latency: AR handshake edge to s_rvalid high is 2 cycles (in range).
- RD_RESP: s_rvalid=1; s_rdata/s_rresp stable until s_rready; on handshake go to IDLE. Next AR is accepted no earlier than the following cycle.
- IDLE, write selected: requires s_awvalid AND s_wvalid in the same cycle. s_awready=s_wready=1 together for one cycle; AW or W alone is never accepted.
  - ALLOW_WRITE=1 and in range: rom_chipselect=rom_write=rom_debugaccess=1 for exactly that cycle, rom_byteenable=s_wstrb; bresp=OKAY.
  - ALLOW_WRITE=0: no ROM strobe; bresp=SLVERR(2'b10).
  - Out of range: bresp=DECERR; no strobe.
  - Then go to WR_RESP.
- WR_RESP: s_bvalid=1 until s_bready; then IDLE.
- Arbitration, both read and write eligible in IDLE: alternate using a last-served flag; after reset the read wins first.
- Address low bits [1:0] are ignored (no misalignment error).
- Range check: (addr - BASE_ADDR) < 4*2^ROM_AW, computed in 32-bit unsigned arithmetic; addresses below the base wrap and fail.
- s_rvalid/s_bvalid never deassert without the matching ready.
- Reset mid-transaction: FSM returns to IDLE next edge; pending response is dropped; no ROM strobe in the reset cycle.

Decomposition:
- Shared package pico_axil_pkg:
  - AXI resp constants RESP_OKAY/RESP_SLVERR/RESP_DECERR.
  - FSM state enum.
  - Address-decode helper function in_window(addr, base, aw).
- No sub-module; a single flat FSM.

Test Plan:
- Read 0x0000_0010 with ROM word 4 = 32'hDEADBEEF, rready=1 -> s_rvalid exactly 2 cycles after AR handshake, rdata=DEADBEEF, rresp=0, rom_address=4.
- Read 0x0000_4000 (out of window) -> rresp=2'b11, rdata=0, rom_chipselect never asserted.
- Write 0x8 data 32'h12345678, wstrb=4'b0011, ALLOW_WRITE=0 -> bresp=2'b10, rom_write stays 0; repeat with ALLOW_WRITE=1 -> one-cycle rom_write/debugaccess, byteenable=4'b0011, bresp=0, readback=xxxx5678.
- AW valid 3 cycles before W -> no awready until W valid, then both readies high in the same single cycle.
- Simultaneous AR and AW+W held valid, rready/bready=1 -> order read, write, read (alternation); rready held 0 for 5 cycles -> rvalid/rdata stable throughout.
- Assert reset in RD_WAIT -> next cycle FSM IDLE, s_rvalid=0, all readies 0, no response issued.
